// File: rtl/conv_pe_sequencer.sv
// rtl/conv_pe_sequencer.sv - PE accumulate/capture sequencer walking OFM pixels and output-channel groups
//
// Purpose: after an accepted cal_start, waits START_DELAY cycles, then for every
// output-channel group, OFM row and OFM column (column fastest) issues one
// pixel period of ACC_LEN cycles: RST (pe_reset), ACC_LEN-2 ACC cycles, FIN (pe_finish).
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   cal_start  start request (level, sampled in IDLE only)
//   stall      freezes ACC cycles
//   abort      synchronous return to IDLE from any active state
//   pe_reset   per-PE accumulator clear (RST only, masked for partial group)
//   pe_finish  per-PE result capture (FIN only, masked for partial group)
//   acc_cycle  word index within the current pixel
//   ofm_row / ofm_col / oc_group  indices of the pixel being computed
//   busy       high from WAIT through DONE
//   done       one-cycle completion pulse
module conv_pe_sequencer #(
  parameter int NUM_PE         = 16,
  parameter int KERNEL         = 3,
  parameter int IN_CH          = 16,
  parameter int BYTES_PER_WORD = 4,
  parameter int OFM_H          = 56,
  parameter int OFM_W          = 56,
  parameter int OUT_CH         = 32,
  parameter int START_DELAY    = 2,
  localparam int ACC_LEN = KERNEL * KERNEL * IN_CH / BYTES_PER_WORD,
  localparam int GROUPS  = (OUT_CH + NUM_PE - 1) / NUM_PE,
  localparam int ACC_W   = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1,
  localparam int ROW_W   = (OFM_H > 1) ? $clog2(OFM_H) : 1,
  localparam int COL_W   = (OFM_W > 1) ? $clog2(OFM_W) : 1,
  localparam int GRP_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cal_start,
  input  logic              stall,
  input  logic              abort,
  output logic [NUM_PE-1:0] pe_reset,
  output logic [NUM_PE-1:0] pe_finish,
  output logic [ACC_W-1:0]  acc_cycle,
  output logic [ROW_W-1:0]  ofm_row,
  output logic [COL_W-1:0]  ofm_col,
  output logic [GRP_W-1:0]  oc_group,
  output logic              busy,
  output logic              done
);

  if (ACC_LEN * BYTES_PER_WORD != KERNEL * KERNEL * IN_CH || ACC_LEN < 3) begin : g_bad_cfg
    $error("conv_pe_sequencer: ACC_LEN must be an integer >= 3");
  end

  localparam int WAIT_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  localparam int WAIT_LAST_I = (START_DELAY > 0) ? START_DELAY - 1 : 0;
  localparam int ACC_PRE_I   = ACC_LEN - 2;
  localparam int ROW_LAST_I  = OFM_H - 1;
  localparam int COL_LAST_I  = OFM_W - 1;
  localparam int GRP_LAST_I  = GROUPS - 1;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_LAST_I[WAIT_W-1:0];
  localparam logic [ACC_W-1:0]  ACC_PRE   = ACC_PRE_I[ACC_W-1:0];
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_LAST_I[ROW_W-1:0];
  localparam logic [COL_W-1:0]  COL_LAST  = COL_LAST_I[COL_W-1:0];
  localparam logic [GRP_W-1:0]  GRP_LAST  = GRP_LAST_I[GRP_W-1:0];

  // Only PEs that map to a real output channel are pulsed in the last group.
  function automatic logic [NUM_PE-1:0] last_group_mask();
    logic [NUM_PE-1:0] m;
    for (int i = 0; i < NUM_PE; i++) begin
      m[i] = ((GROUPS - 1) * NUM_PE + i < OUT_CH);
    end
    return m;
  endfunction

  localparam logic [NUM_PE-1:0] LAST_MASK = last_group_mask();

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RST, S_ACC, S_FIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [GRP_W-1:0]  grp_q, grp_d;
  logic [NUM_PE-1:0] group_mask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      acc_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      grp_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      acc_q   <= acc_d;
      row_q   <= row_d;
      col_q   <= col_d;
      grp_q   <= grp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    acc_d   = acc_q;
    row_d   = row_q;
    col_d   = col_q;
    grp_d   = grp_q;
    case (state_q)
      S_IDLE: begin
        if (cal_start) begin
          wait_d  = '0;
          acc_d   = '0;
          row_d   = '0;
          col_d   = '0;
          grp_d   = '0;
          state_d = (START_DELAY == 0) ? S_RST : S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_RST;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RST: begin
        acc_d   = acc_q + 1'b1;
        state_d = S_ACC;
      end
      S_ACC: begin
        // The last ACC cycle hands ACC_LEN-1 to FIN, so FIN needs no extra count.
        if (!stall) begin
          acc_d = acc_q + 1'b1;
          if (acc_q == ACC_PRE) begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        acc_d   = '0;
        state_d = S_RST;
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            row_d = '0;
            if (grp_q == GRP_LAST) begin
              grp_d   = '0;
              state_d = S_DONE;
            end else begin
              grp_d = grp_q + 1'b1;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort outranks stall and the FIN advance; indices return to zero with it.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      wait_d  = '0;
      acc_d   = '0;
      row_d   = '0;
      col_d   = '0;
      grp_d   = '0;
    end
  end

  assign group_mask = (grp_q == GRP_LAST) ? LAST_MASK : '1;
  assign pe_reset   = (state_q == S_RST) ? group_mask : '0;
  assign pe_finish  = (state_q == S_FIN) ? group_mask : '0;
  assign acc_cycle  = acc_q;
  assign ofm_row    = row_q;
  assign ofm_col    = col_q;
  assign oc_group   = grp_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// tb/tb_conv_pe_sequencer.sv - self-checking bench for conv_pe_sequencer against a time-based reference model
module tb_conv_pe_sequencer;
  localparam int NPE = 4, KER = 3, INC = 4, BPW = 4, H = 2, W = 3, OC = 6, SD = 2;
  localparam int ACC_LEN = KER * KER * INC / BPW;
  localparam int GROUPS  = (OC + NPE - 1) / NPE;
  localparam int PIX     = GROUPS * H * W;
  localparam int RUNLEN  = SD + PIX * ACC_LEN;

  logic clk = 1'b0, reset = 1'b0, cal_start = 1'b0, stall = 1'b0, abort = 1'b0;
  logic [3:0] pe_reset, pe_finish, acc_cycle;
  logic [0:0] ofm_row, oc_group;
  logic [1:0] ofm_col;
  logic       busy, done;

  logic        d_cal_start = 1'b0, d_stall = 1'b0, d_abort = 1'b0;
  logic [15:0] d_pe_reset, d_pe_finish;
  logic [5:0]  d_acc_cycle, d_ofm_row, d_ofm_col;
  logic [0:0]  d_oc_group;
  logic        d_busy, d_done;

  int errors = 0, checks = 0, cyc = 0;
  bit run = 1'b0;
  int t = 0;

  conv_pe_sequencer #(.NUM_PE(NPE), .KERNEL(KER), .IN_CH(INC), .BYTES_PER_WORD(BPW),
                      .OFM_H(H), .OFM_W(W), .OUT_CH(OC), .START_DELAY(SD)) dut (
    .clk(clk), .reset(reset), .cal_start(cal_start), .stall(stall), .abort(abort),
    .pe_reset(pe_reset), .pe_finish(pe_finish), .acc_cycle(acc_cycle),
    .ofm_row(ofm_row), .ofm_col(ofm_col), .oc_group(oc_group), .busy(busy), .done(done));

  conv_pe_sequencer dut_def (
    .clk(clk), .reset(reset), .cal_start(d_cal_start), .stall(d_stall), .abort(d_abort),
    .pe_reset(d_pe_reset), .pe_finish(d_pe_finish), .acc_cycle(d_acc_cycle),
    .ofm_row(d_ofm_row), .ofm_col(d_ofm_col), .oc_group(d_oc_group), .busy(d_busy), .done(d_done));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mask_of(int g);
    int m = 0;
    for (int i = 0; i < NPE; i++) if (g * NPE + i < OC) m |= (1 << i);
    return m;
  endfunction

  // Model state is just "running" plus t = non-stalled cycles since acceptance.
  function automatic bit in_acc_phase();
    int ph;
    if (!run || t < SD || t >= RUNLEN) return 1'b0;
    ph = (t - SD) % ACC_LEN;
    return (ph >= 1 && ph <= ACC_LEN - 2);
  endfunction

  task automatic check_outputs();
    int p, ph;
    int e_pr = 0, e_pf = 0, e_acc = 0, e_row = 0, e_col = 0, e_grp = 0, e_busy = 0, e_done = 0;
    if (run) begin
      e_busy = 1;
      if (t == RUNLEN) e_done = 1;
      else if (t >= SD) begin
        p     = (t - SD) / ACC_LEN;
        ph    = (t - SD) % ACC_LEN;
        e_grp = p / (H * W);
        e_row = (p % (H * W)) / W;
        e_col = p % W;
        e_acc = ph;
        if (ph == 0) e_pr = mask_of(e_grp);
        if (ph == ACC_LEN - 1) e_pf = mask_of(e_grp);
      end
    end
    chk("pe_reset", 32'(pe_reset), e_pr);
    chk("pe_finish", 32'(pe_finish), e_pf);
    chk("acc_cycle", 32'(acc_cycle), e_acc);
    chk("ofm_row", 32'(ofm_row), e_row);
    chk("ofm_col", 32'(ofm_col), e_col);
    chk("oc_group", 32'(oc_group), e_grp);
    chk("busy", 32'(busy), e_busy);
    chk("done", 32'(done), e_done);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) run = 1'b0;
    else if (!run) begin
      if (cal_start) begin run = 1'b1; t = 0; end
    end else if (abort || t == RUNLEN) run = 1'b0;
    else if (!(stall && in_acc_phase())) t++;
    cyc++;
    #1;
    check_outputs();
  endtask

  initial begin
    int first_rst, first_fin, last_fin, nfin, ndone, done_cyc, acc_cyc, c0, nrst, k;
    int fin_mask[$], fin_col[$], fin_grp[$];
    int r, rmask, f, fmask, facc;

    // Reset state
    step(); step();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_def_busy", 32'(d_busy), 0);
    chk("reset_def_pe_reset", 32'(d_pe_reset), 0);
    reset = 1'b1;
    step();

    // Basic run with partial last group
    cal_start = 1'b1; step(); cal_start = 1'b0; acc_cyc = cyc;
    first_rst = -1; first_fin = -1; last_fin = -1; nfin = 0; done_cyc = -1;
    for (int i = 0; i < 200 && done_cyc < 0; i++) begin
      step();
      if (pe_reset != 0 && first_rst < 0) first_rst = cyc - acc_cyc;
      if (pe_finish != 0) begin
        if (first_fin < 0) first_fin = cyc - acc_cyc;
        else chk("fin_interval", cyc - last_fin, ACC_LEN);
        last_fin = cyc;
        nfin++;
        fin_mask.push_back(32'(pe_finish));
        fin_col.push_back(32'(ofm_col));
        fin_grp.push_back(32'(oc_group));
      end
      if (done) done_cyc = cyc - acc_cyc;
    end
    chk("first_pe_reset_cycle", first_rst, 2);
    chk("first_pe_finish_cycle", first_fin, 10);
    chk("pe_finish_count", nfin, 12);
    chk("done_cycle", done_cyc, 110);
    for (int i = 0; i < fin_mask.size(); i++) begin
      chk("fin_mask", fin_mask[i], (i < 6) ? 32'hF : 32'h3);
      chk("fin_col", fin_col[i], i % 3);
      chk("fin_group", fin_grp[i], i / 6);
    end
    step();
    chk("idle_after_done", 32'(busy), 0);

    // Stall inside ACC, then stall while FIN is showing
    cal_start = 1'b1; step(); cal_start = 1'b0;
    c0 = -1; k = 0;
    while (!(c0 >= 0 && acc_cycle == 4) && k < 50) begin
      step(); k++;
      if (pe_reset != 0) c0 = cyc;
    end
    chk("stall_reach_acc4", 32'(acc_cycle), 4);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold_acc", 32'(acc_cycle), 4);
      chk("stall_no_pe", 32'(pe_reset | pe_finish), 0);
    end
    stall = 1'b0;
    k = 0;
    while (pe_finish == 0 && k < 20) begin step(); k++; end
    chk("stall_fin_seen", 32'(pe_finish), 32'hF);
    stall = 1'b1; step(); stall = 1'b0;
    chk("fin_not_delayed", 32'(pe_reset), 32'hF);
    chk("stalled_pixel_period", cyc - c0, 14);

    // Abort mid-ACC of pixel 3 (two more RSTs after pixel 1)
    nrst = 0; k = 0;
    while (nrst < 2 && k < 40) begin step(); k++; if (pe_reset != 0) nrst++; end
    chk("abort_pixel3_row", 32'(ofm_row), 1);
    step(); step(); step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_pe", 32'(pe_reset | pe_finish), 0);
    chk("abort_idx", 32'({ofm_row, ofm_col, oc_group, acc_cycle}), 0);
    ndone = 0;
    for (int i = 0; i < 5; i++) begin step(); if (done) ndone++; end
    chk("abort_no_done", ndone, 0);

    // Restart after abort begins at pixel 0, then reset during FIN
    cal_start = 1'b1; step(); cal_start = 1'b0; acc_cyc = cyc; k = 0;
    while (pe_reset == 0 && k < 10) begin step(); k++; end
    chk("restart_rst_cycle", cyc - acc_cyc, 2);
    chk("restart_idx", 32'({ofm_row, ofm_col, oc_group}), 0);
    k = 0;
    while (pe_finish == 0 && k < 20) begin step(); k++; end
    chk("pre_reset_fin", 32'(pe_finish), 32'hF);
    #3 reset = 1'b0; #1;
    chk("async_reset_fin_pe_finish", 32'(pe_finish), 0);
    chk("async_reset_fin_busy", 32'(busy), 0);
    run = 1'b0;
    step(); reset = 1'b1;

    // Reset during WAIT
    cal_start = 1'b1; step(); cal_start = 1'b0;
    chk("wait_busy", 32'(busy), 1);
    #3 reset = 1'b0; #1;
    chk("async_reset_wait_busy", 32'(busy), 0);
    run = 1'b0;
    step(); reset = 1'b1;

    // cal_start held high through the run: exactly one run
    cal_start = 1'b1; nfin = 0; ndone = 0; k = 0;
    while (ndone == 0 && k < 200) begin
      step(); k++;
      if (pe_finish != 0) nfin++;
      if (done) begin ndone++; cal_start = 1'b0; end
    end
    for (int i = 0; i < 20; i++) begin step(); if (done) ndone++; if (pe_finish != 0) nfin++; end
    chk("held_start_done_count", ndone, 1);
    chk("held_start_fin_count", nfin, 12);
    chk("held_start_idle", 32'(busy), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      cal_start = ($urandom_range(0, 9) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 299) == 0);
      step();
    end
    cal_start = 1'b0; stall = 1'b0; abort = 1'b0;
    abort = 1'b1; step(); abort = 1'b0;

    // Default-parameter instance: first pixel timing
    d_cal_start = 1'b1; step(); d_cal_start = 1'b0;
    chk("def_busy", 32'(d_busy), 1);
    r = -1; rmask = 0; f = -1; fmask = 0; facc = 0;
    for (int i = 1; i <= 60 && f < 0; i++) begin
      step();
      if (d_pe_reset != 0 && r < 0) begin r = i; rmask = 32'(d_pe_reset); end
      if (d_pe_finish != 0) begin f = i; fmask = 32'(d_pe_finish); facc = 32'(d_acc_cycle); end
    end
    chk("def_rst_cycle", r, 2);
    chk("def_rst_mask", rmask, 32'hFFFF);
    chk("def_fin_cycle", f, 37);
    chk("def_fin_mask", fmask, 32'hFFFF);
    chk("def_fin_acc", facc, 35);
    d_abort = 1'b1; step(); d_abort = 1'b0;
    chk("def_abort_busy", 32'(d_busy), 0);
    chk("def_abort_done", 32'(d_done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
